ascon_perm_sched: RTL and testbench

Round scheduler for the single-round ASCON permutation datapath (constant addition, S-box layer, linear diffusion layer). It accepts a 320-bit state and a round-count mode over a valid/ready handshake. It iterates the state through the round datapath once per clock, generating the round constant and enable each cycle. It returns the permuted state over a second valid/ready handshake. One instance sits between the ASCON-128/128a mode FSM and the round datapath, so one round unit serves p^a (12 rounds) and p^b (6 or 8 rounds).

---
 rtl/ascon_pkg.sv | 38 +++
 rtl/ascon_rc_gen.sv | 37 +++
 rtl/ascon_perm_sched.sv | 94 +++++++++
 tb/tb_ascon_perm_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON permutation round scheduler.
// Round constant for index i is {~i, i}; shorter permutations start part-way in.
package ascon_pkg;

  localparam int ASCON_STATE_W = 320;

  typedef enum logic [1:0] {
    MODE_P12 = 2'b00,
    MODE_P8  = 2'b01,
    MODE_P6  = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [3:0] START_P12 = 4'd0;
  localparam logic [3:0] START_P8  = 4'd4;
  localparam logic [3:0] START_P6  = 4'd6;
  localparam logic [3:0] LAST_RI   = 4'd11;

  function automatic logic [7:0] rc(input logic [3:0] i);
    return {~i, i};
  endfunction

  // Reserved mode falls back to the full 12-round permutation.
  function automatic logic [3:0] start_idx(input logic [1:0] mode);
    case (mode)
      MODE_P8: return START_P8;
      MODE_P6: return START_P6;
      default: return START_P12;
    endcase
  endfunction

endpackage

// File: rtl/ascon_rc_gen.sv
// Round index counter: loads the start index, steps once per round,
// and flags the final round (index 11).
module ascon_rc_gen
  import ascon_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] start_i,
  input  logic       inc_i,
  output logic [3:0] ri_o,
  output logic       last_o
);

  logic [3:0] ri_q, ri_d;

  always_comb begin
    ri_d = ri_q;
    if (load_i) begin
      ri_d = start_i;
    end else if (inc_i) begin
      ri_d = ri_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ri_q <= 4'd0;
    end else begin
      ri_q <= ri_d;
    end
  end

  assign ri_o   = ri_q;
  assign last_o = (ri_q == LAST_RI);

endmodule

// File: rtl/ascon_perm_sched.sv
// Drives an external single-round ASCON datapath for 12/8/6 rounds per request;
// a new request may be taken in the same cycle a result is consumed.
module ascon_perm_sched
  import ascon_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ASCON_STATE_W-1:0] in_state,
  input  logic [1:0]               in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ASCON_STATE_W-1:0] out_state,
  output logic                     busy,
  output logic                     dp_enable,
  output logic [7:0]               dp_rc,
  output logic [ASCON_STATE_W-1:0] dp_x_out,
  input  logic [ASCON_STATE_W-1:0] dp_x_in
);

  state_e                   state_q, state_d;
  logic [ASCON_STATE_W-1:0] st_q, st_d;
  logic                     load, inc, last;
  logic [3:0]               ri;

  ascon_rc_gen u_rc_gen (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .start_i (start_idx(in_mode)),
    .inc_i   (inc),
    .ri_o    (ri),
    .last_o  (last)
  );

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    load      = 1'b0;
    inc       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_enable = 1'b0;
    dp_rc     = 8'h00;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          st_d    = in_state;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        dp_enable = 1'b1;
        dp_rc     = rc(ri);
        st_d      = dp_x_in;
        inc       = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Consuming the result and accepting the next request share one cycle.
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            st_d    = in_state;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
    end
  end

  assign out_state = st_q;
  assign dp_x_out  = st_q;
  assign busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Scoreboard bench for ascon_perm_sched with an additive stub round datapath.
module tb_ascon_perm_sched;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [319:0] in_state = '0;
  logic [1:0]   in_mode = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [319:0] out_state;
  logic         busy;
  logic         dp_enable;
  logic [7:0]   dp_rc;
  logic [319:0] dp_x_out;
  logic [319:0] dp_x_in;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ordy_mode = 0;  // 0: hold low, 1: hold high, 2: random

  logic [319:0] res_q[$];
  logic [7:0]   rc_q[$];
  int           lat_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dp_x_in = dp_x_out + {312'b0, dp_rc};

  ascon_perm_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy),
    .dp_enable (dp_enable),
    .dp_rc     (dp_rc),
    .dp_x_out  (dp_x_out),
    .dp_x_in   (dp_x_in)
  );

  always @(posedge clk) begin
    #1;
    case (ordy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom);
    endcase
  end

  function automatic int nrounds(input logic [1:0] m);
    if (m == 2'b01) return 8;
    if (m == 2'b10) return 6;
    return 12;
  endfunction

  // Round r (0..11) adds constant (15-r)*16 + r; an N-round run uses the last N rounds.
  function automatic logic [7:0] rc_of(input int r);
    return 8'((15 - r) * 16 + r);
  endfunction

  function automatic logic [319:0] model(input logic [319:0] s, input logic [1:0] m);
    logic [319:0] acc = s;
    for (int r = 12 - nrounds(m); r < 12; r++) acc = acc + 320'(rc_of(r));
    return acc;
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [319:0] s, input logic [1:0] m);
    bit ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_state = s; in_mode = m;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        ok = 1'b1;
        res_q.push_back(model(s, m));
        for (int r = 12 - nrounds(m); r < 12; r++) rc_q.push_back(rc_of(r));
        lat_q.push_back(cyc + 1 + nrounds(m));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_state = rand_state(); in_mode = 2'($urandom);
    if (!ok) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready never seen, required 1");
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(posedge clk); #2;
      if (res_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", res_q.size());
    end
  endtask

  // Monitor: compares everything the DUT presents against the queued expectations.
  logic         prev_stall = 1'b0;
  logic         prev_ov = 1'b0;
  logic [319:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_ov    = 1'b0;
    end else begin
      check("busy_eq_enable", 320'(busy), 320'(dp_enable));
      if (dp_enable) begin
        if (rc_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_round: dp_rc %h with no round pending", dp_rc);
        end else begin
          check("dp_rc", 320'(dp_rc), 320'(rc_q.pop_front()));
        end
      end else begin
        check("dp_rc_idle", 320'(dp_rc), 320'(0));
      end
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid: out_valid with no request pending");
        end else begin
          check("latency", 320'(cyc), 320'(lat_q.pop_front()));
        end
      end
      if (prev_stall && out_valid) check("stall_stable", out_state, prev_out);
      if (out_valid && !out_ready) check("stall_in_ready", 320'(in_ready), 320'(0));
      if (out_valid && out_ready) begin
        if (res_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result: %h with no result pending", out_state);
        end else begin
          check("out_state", out_state, res_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_ov    = out_valid;
      prev_out   = out_state;
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 320'(in_ready), 320'(1));
    check("rst_out_valid", 320'(out_valid), 320'(0));
    check("rst_busy", 320'(busy), 320'(0));
    check("rst_dp_enable", 320'(dp_enable), 320'(0));
    check("rst_out_state", out_state, 320'(0));

    // Each mode from a zero state, consumer always ready.
    ordy_mode = 1;
    for (int m = 0; m < 4; m++) begin
      send('0, 2'(m));
      drain();
    end

    // Consumer stalls in DONE while a new request waits, then back-to-back accept.
    @(negedge clk);
    ordy_mode = 0;
    send('0, 2'b00);
    for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
    check("stall_reached", 320'(out_valid), 320'(1));
    @(posedge clk); #1;
    in_valid = 1'b1; in_state = '0; in_mode = 2'b10;
    repeat (5) @(negedge clk);
    ordy_mode = 1;
    send('0, 2'b10);
    @(negedge clk);
    check("b2b_busy", 320'(busy), 320'(1));
    check("b2b_rc", 320'(dp_rc), 320'(8'h96));
    drain();

    // Reset in the middle of a 12-round run discards the result.
    send('0, 2'b00);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    res_q.delete(); rc_q.delete(); lat_q.delete();
    @(negedge clk);
    check("midrst_in_ready", 320'(in_ready), 320'(1));
    check("midrst_out_valid", 320'(out_valid), 320'(0));
    check("midrst_dp_enable", 320'(dp_enable), 320'(0));
    send('0, 2'b00);
    drain();

    // Randomized states, modes, gaps and consumer backpressure.
    ordy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      send(rand_state(), 2'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    @(negedge clk);
    ordy_mode = 1;
    drain();
    check("rc_queue_empty", 320'(rc_q.size()), 320'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
